// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared VGA-path definitions: visible screen size, the 10-bit pixel
// coordinate type, the 24-bit RGB pixel struct, the black constant, the
// window-printer state enum and the 8-bit colour expansion helpers.
// ---------------------------------------------------------------------------
package vga_pkg;

   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;

   typedef logic [9:0] pixel_coord_t;

   typedef struct packed {
      logic [7:0] red;
      logic [7:0] green;
      logic [7:0] blue;
   } rgb888_t;

   localparam rgb888_t BLACK = '{red: 8'h00, green: 8'h00, blue: 8'h00};

   typedef enum logic {
      WAIT_SYNC = 1'b0,
      ACTIVE    = 1'b1
   } win_state_t;

   // RGB332 to RGB888: each field is replicated so full-scale codes reach 8'hFF
   function automatic rgb888_t rgb332_expand(input logic [7:0] c);
      rgb888_t px;
      px.red   = {c[7:5], c[7:5], c[7:6]};
      px.green = {c[4:2], c[4:2], c[4:3]};
      px.blue  = {c[1:0], c[1:0], c[1:0], c[1:0]};
      return px;
   endfunction

   // Grayscale: the same level on all three channels
   function automatic rgb888_t gray_expand(input logic [7:0] c);
      rgb888_t px;
      px.red   = c;
      px.green = c;
      px.blue  = c;
      return px;
   endfunction

endpackage

// File: rtl/latency_shift.sv
// ---------------------------------------------------------------------------
// latency_shift
// Parametrised delay line: q_o is d_i delayed by DEPTH clock cycles.
// Used to align side-band flags with data that comes back from a
// fixed-latency memory, and to delay sync signals in the timing generator.
// Ports:
//   clk_i  clock
//   rst_i  asynchronous active-high reset, clears every stage
//   d_i    WIDTH-bit input
//   q_o    WIDTH-bit output, DEPTH cycles later
// ---------------------------------------------------------------------------
module latency_shift #(
   parameter int DEPTH = 1,
   parameter int WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stage_q [DEPTH];

   // Shift the input through DEPTH registers; reset empties the line
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/scaled_window_printer.sv
// ---------------------------------------------------------------------------
// scaled_window_printer
// Draws an IMG_W x IMG_H image held in video RAM at (X_START, Y_START),
// replicating every source pixel SCALE x SCALE times. The RAM address is
// derived from the raster position, so it re-locks every frame at (0,0).
// The returned RAM data is aligned to RD_LATENCY and shown either as
// grayscale or expanded from RGB332. RGB trails pixel_x/pixel_y by
// RD_LATENCY+2 cycles.
// Ports:
//   vga_clk     pixel clock
//   rst         asynchronous active-high reset
//   video_on    active-area flag from the timing generator
//   pixel_x/y   current raster column/row
//   color       RAM read data, RD_LATENCY cycles after address
//   mode        0 = grayscale, 1 = RGB332 (sampled at each (0,0))
//   address     RAM read address
//   red/green/blue  pixel output
//   frame_done  one-cycle pulse after the last image pixel is fetched
// Optional build macro: SCALED_WINDOW_PRINTER_BORDER_EN draws a one-pixel
// BORDER_COLOR ring just outside the window.
// ---------------------------------------------------------------------------
module scaled_window_printer
   import vga_pkg::*;
#(
   parameter int         X_START      = 170,
   parameter int         Y_START      = 90,
   parameter int         IMG_W        = 300,
   parameter int         IMG_H        = 300,
   parameter int         SCALE        = 1,
   parameter int         ADDR_W       = 18,
   parameter int         BASE_ADDR    = 324,
   parameter int         RD_LATENCY   = 1,
   parameter logic [7:0] BORDER_COLOR = 8'hFF
) (
   input  logic              vga_clk,
   input  logic              rst,
   input  logic              video_on,
   input  pixel_coord_t      pixel_x,
   input  pixel_coord_t      pixel_y,
   input  logic [7:0]        color,
   input  logic              mode,
   output logic [ADDR_W-1:0] address,
   output logic [7:0]        red,
   output logic [7:0]        green,
   output logic [7:0]        blue,
   output logic              frame_done
);

   localparam int X_END = X_START + IMG_W * SCALE;
   localparam int Y_END = Y_START + IMG_H * SCALE;
   localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [1:0]        S_MAX    = 2'(SCALE - 1);
   localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0]  ROW_MAX  = ROW_W'(IMG_H - 1);
   localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
`ifdef SCALED_WINDOW_PRINTER_BORDER_EN
   localparam int FLAG_W = 2;
`else
   localparam int FLAG_W = 1;
`endif

   // Reject configurations the address arithmetic or the screen cannot hold
   if (SCALE < 1 || SCALE > 4) begin : g_bad_scale
      $error("scaled_window_printer: SCALE must be 1..4");
   end
   if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_bad_latency
      $error("scaled_window_printer: RD_LATENCY must be 1..3");
   end
   if (longint'(BASE_ADDR) + longint'(IMG_W) * longint'(IMG_H) > (longint'(1) << ADDR_W)) begin : g_bad_fit
      $error("scaled_window_printer: image does not fit in ADDR_W address space");
   end
   if (X_END > H_ACTIVE || Y_END > V_ACTIVE || $bits(BORDER_COLOR) != 8) begin : g_bad_window
      $error("scaled_window_printer: window exceeds the visible screen");
   end

   win_state_t state_q, state_d;
   logic run, latch_mode, at_origin, in_win;
   logic mode_q, mode_d;
   logic [1:0] sx_q, sx_d, sx_b, sy_q, sy_d, sy_b;
   logic [COL_W-1:0] col_q, col_d, col_b;
   logic [ROW_W-1:0] row_q, row_d, row_b;
   logic [ADDR_W-1:0] rbase_q, rbase_d, rbase_b;
   logic [ADDR_W-1:0] address_q, address_d;
   logic last_wrap, frame_done_q;
   logic [FLAG_W-1:0] flag_d, flag_q, flag_dly;
   rgb888_t rgb_q, rgb_d;

   assign at_origin = (pixel_x == '0) && (pixel_y == '0);
   assign in_win = video_on
                   && (int'(pixel_x) >= X_START) && (int'(pixel_x) < X_END)
                   && (int'(pixel_y) >= Y_START) && (int'(pixel_y) < Y_END);

   // State register: reset always parks in WAIT_SYNC so no partial frame is drawn
   always_ff @(posedge vga_clk or posedge rst) begin
      if (rst) begin
         state_q <= WAIT_SYNC;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: leave WAIT_SYNC only at the top-left corner of a frame
   always_comb begin
      state_d = state_q;
      case (state_q)
         WAIT_SYNC: if (at_origin) state_d = ACTIVE;
         ACTIVE:    state_d = ACTIVE;
         default:   state_d = WAIT_SYNC;
      endcase
   end

   // FSM outputs: the (0,0) cycle already counts as running so a window
   // starting at the origin is not missed; mode is sampled there each frame
   always_comb begin
      run        = 1'b0;
      latch_mode = 1'b0;
      case (state_q)
         WAIT_SYNC: begin
            run        = at_origin;
            latch_mode = at_origin;
         end
         ACTIVE: begin
            run        = 1'b1;
            latch_mode = at_origin;
         end
         default: begin
            run        = 1'b0;
            latch_mode = 1'b0;
         end
      endcase
   end

   // Raster-to-image counters. At (0,0) they restart from zero, which keeps
   // the address locked to the raster. The address is formed from the
   // counters before they advance, so outside the window it names the next
   // pixel to fetch. row_base accumulates IMG_W per image row instead of
   // multiplying.
   always_comb begin
      sx_b    = at_origin ? '0 : sx_q;
      sy_b    = at_origin ? '0 : sy_q;
      col_b   = at_origin ? '0 : col_q;
      row_b   = at_origin ? '0 : row_q;
      rbase_b = at_origin ? '0 : rbase_q;
      sx_d      = sx_b;
      sy_d      = sy_b;
      col_d     = col_b;
      row_d     = row_b;
      rbase_d   = rbase_b;
      last_wrap = 1'b0;
      if (run && in_win) begin
         if (sx_b != S_MAX) begin
            sx_d = sx_b + 2'd1;
         end else begin
            sx_d = '0;
            if (col_b != COL_MAX) begin
               col_d = col_b + COL_W'(1);
            end else begin
               col_d = '0;
               if (sy_b != S_MAX) begin
                  sy_d = sy_b + 2'd1;
               end else begin
                  sy_d = '0;
                  if (row_b != ROW_MAX) begin
                     row_d   = row_b + ROW_W'(1);
                     rbase_d = rbase_b + ROW_STEP;
                  end else begin
                     row_d     = '0;
                     rbase_d   = '0;
                     last_wrap = 1'b1;
                  end
               end
            end
         end
      end
      address_d = run ? (BASE + rbase_b + ADDR_W'(col_b)) : BASE;
      mode_d    = latch_mode ? mode : mode_q;
   end

   // Window and ring flags enter the alignment pipe only while running
`ifdef SCALED_WINDOW_PRINTER_BORDER_EN
   logic in_ring;
   assign in_ring = video_on && !in_win
                    && (int'(pixel_x) >= X_START - 1) && (int'(pixel_x) <= X_END)
                    && (int'(pixel_y) >= Y_START - 1) && (int'(pixel_y) <= Y_END);
   assign flag_d = run ? {in_ring, in_win} : '0;
`else
   assign flag_d = run ? in_win : 1'b0;
`endif

   // Counter, address and flag registers; the flag register is the stage
   // that matches the address register, the delay line matches the RAM
   always_ff @(posedge vga_clk or posedge rst) begin
      if (rst) begin
         sx_q         <= '0;
         sy_q         <= '0;
         col_q        <= '0;
         row_q        <= '0;
         rbase_q      <= '0;
         address_q    <= BASE;
         mode_q       <= 1'b0;
         frame_done_q <= 1'b0;
         flag_q       <= '0;
      end else begin
         sx_q         <= sx_d;
         sy_q         <= sy_d;
         col_q        <= col_d;
         row_q        <= row_d;
         rbase_q      <= rbase_d;
         address_q    <= address_d;
         mode_q       <= mode_d;
         frame_done_q <= last_wrap;
         flag_q       <= flag_d;
      end
   end

   latency_shift #(
      .DEPTH(RD_LATENCY),
      .WIDTH(FLAG_W)
   ) u_align (
      .clk_i(vga_clk),
      .rst_i(rst),
      .d_i  (flag_q),
      .q_o  (flag_dly)
   );

   // Pixel colour from the RAM word that lines up with the delayed flags
   always_comb begin
      rgb_d = BLACK;
      if (flag_dly[0]) begin
         rgb_d = mode_q ? rgb332_expand(color) : gray_expand(color);
      end
`ifdef SCALED_WINDOW_PRINTER_BORDER_EN
      else if (flag_dly[1]) begin
         rgb_d = gray_expand(BORDER_COLOR);
      end
`endif
   end

   // Output pixel register
   always_ff @(posedge vga_clk or posedge rst) begin
      if (rst) begin
         rgb_q <= BLACK;
      end else begin
         rgb_q <= rgb_d;
      end
   end

   assign address    = address_q;
   assign frame_done = frame_done_q;
   assign red        = rgb_q.red;
   assign green      = rgb_q.green;
   assign blue       = rgb_q.blue;

endmodule

// File: tb/tb_scaled_window_printer.sv
// ---------------------------------------------------------------------------
// tb_scaled_window_printer
// Directed bench for scaled_window_printer. Three instances share the raster
// inputs: A (defaults), B (SCALE=2, 4x2 image, base 0), C (RD_LATENCY=3).
// Each has a small RAM model returning address[7:0] ^ key.
// ---------------------------------------------------------------------------
module tb_scaled_window_printer;

   logic        clk = 1'b0;
   logic        rst;
   logic        video_on;
   logic [9:0]  px, py;
   logic        mode;
   logic [7:0]  colA, colB, colC;
   logic [17:0] addrA, addrB, addrC;
   logic [7:0]  rA, gA, bA, rB, gB, bB, rC, gC, bC;
   logic        doneA, doneB, doneC;

   int checks = 0;
   int errors = 0;

`ifdef SCALED_WINDOW_PRINTER_BORDER_EN
   localparam logic [23:0] BC = 24'hFFFFFF;
`else
   localparam logic [23:0] BC = 24'h000000;
`endif

   typedef struct {
      logic [9:0]  x;
      logic [9:0]  y;
      logic        vid;
      logic        md;
      logic [17:0] expAddr;
      logic [23:0] expRgb;
      logic        expDone;
   } vec_t;

   vec_t vecs[64];
   int   nVec;

   always #5 clk = ~clk;

   scaled_window_printer dutA (
      .vga_clk(clk), .rst(rst), .video_on(video_on), .pixel_x(px), .pixel_y(py),
      .color(colA), .mode(mode), .address(addrA), .red(rA), .green(gA), .blue(bA),
      .frame_done(doneA));

   scaled_window_printer #(
      .X_START(2), .Y_START(1), .IMG_W(4), .IMG_H(2), .SCALE(2), .BASE_ADDR(0)
   ) dutB (
      .vga_clk(clk), .rst(rst), .video_on(video_on), .pixel_x(px), .pixel_y(py),
      .color(colB), .mode(mode), .address(addrB), .red(rB), .green(gB), .blue(bB),
      .frame_done(doneB));

   scaled_window_printer #(
      .RD_LATENCY(3)
   ) dutC (
      .vga_clk(clk), .rst(rst), .video_on(video_on), .pixel_x(px), .pixel_y(py),
      .color(colC), .mode(mode), .address(addrC), .red(rC), .green(gC), .blue(bC),
      .frame_done(doneC));

   function automatic logic [7:0] ramData(input logic [17:0] a, input logic [7:0] key);
      return a[7:0] ^ key;
   endfunction

   // RAM models: one-cycle read for A and B, three-cycle read for C
   logic [7:0] pipeC [3];
   always @(posedge clk) begin
      colA     <= ramData(addrA, 8'hA6);
      colB     <= ramData(addrB, 8'h80);
      pipeC[0] <= ramData(addrC, 8'h1E);
      pipeC[1] <= pipeC[0];
      pipeC[2] <= pipeC[1];
   end
   assign colC = pipeC[2];

   function automatic logic [17:0] outAddr(input int w);
      case (w)
         0:       return addrA;
         1:       return addrB;
         default: return addrC;
      endcase
   endfunction

   function automatic logic [23:0] outRgb(input int w);
      case (w)
         0:       return {rA, gA, bA};
         1:       return {rB, gB, bB};
         default: return {rC, gC, bC};
      endcase
   endfunction

   function automatic logic outDone(input int w);
      case (w)
         0:       return doneA;
         1:       return doneB;
         default: return doneC;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input int x, input int y, input logic v, input logic m);
      px       = 10'(x);
      py       = 10'(y);
      video_on = v;
      mode     = m;
      @(posedge clk);
      #1;
   endtask

   task automatic addVec(input int x, input int y, input logic v, input logic m,
                         input int a, input logic [23:0] rgb, input logic d);
      vecs[nVec].x       = 10'(x);
      vecs[nVec].y       = 10'(y);
      vecs[nVec].vid     = v;
      vecs[nVec].md      = m;
      vecs[nVec].expAddr = 18'(a);
      vecs[nVec].expRgb  = rgb;
      vecs[nVec].expDone = d;
      nVec++;
   endtask

   task automatic doReset();
      rst = 1'b1;
      applyStimulus(5, 5, 1'b0, 1'b0);
      rst = 1'b0;
      applyStimulus(5, 5, 1'b0, 1'b0);
   endtask

   // Address and frame_done are checked right after each vector's edge,
   // RGB lat+1 edges later; idle origin cycles flush the pipeline
   task automatic runTable(input int w, input int lat, input string tag);
      int k;
      for (int i = 0; i < nVec + lat + 1; i++) begin
         if (i < nVec) begin
            applyStimulus(int'(vecs[i].x), int'(vecs[i].y), vecs[i].vid, vecs[i].md);
            checkOutput($sformatf("%s addr[%0d]", tag, i), 32'(outAddr(w)), 32'(vecs[i].expAddr));
            checkOutput($sformatf("%s done[%0d]", tag, i), 32'(outDone(w)), 32'(vecs[i].expDone));
         end else begin
            applyStimulus(0, 0, 1'b0, 1'b0);
         end
         if (i >= lat + 1) begin
            k = i - lat - 1;
            checkOutput($sformatf("%s rgb[%0d]", tag, k), 32'(outRgb(w)), 32'(vecs[k].expRgb));
         end
      end
   endtask

   initial begin
      int yb;
      int a;
      rst = 1'b0;
      px = '0; py = 10'd5; video_on = 1'b0; mode = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checkOutput("reset addrA", 32'(addrA), 32'd324);
      checkOutput("reset addrB", 32'(addrB), 32'd0);
      checkOutput("reset rgbA", 32'({rA, gA, bA}), 32'd0);
      checkOutput("reset doneA", 32'(doneA), 32'd0);

      // A: defaults, mode latching, video_on gaps, ring pixels
      doReset();
      nVec = 0;
      addVec(0,   0,   1'b0, 1'b1, 324, 24'h000000, 1'b0);
      addVec(169, 90,  1'b1, 1'b1, 324, BC,         1'b0);
      addVec(170, 90,  1'b1, 1'b1, 324, 24'hFF00AA, 1'b0);
      addVec(171, 90,  1'b1, 1'b0, 325, 24'hFF00FF, 1'b0);
      addVec(172, 90,  1'b1, 1'b0, 326, 24'hFF0000, 1'b0);
      addVec(173, 90,  1'b0, 1'b0, 327, 24'h000000, 1'b0);
      addVec(173, 90,  1'b1, 1'b0, 327, 24'hFF0055, 1'b0);
      addVec(470, 90,  1'b1, 1'b0, 328, BC,         1'b0);
      addVec(470, 389, 1'b1, 1'b0, 328, BC,         1'b0);
      addVec(471, 389, 1'b1, 1'b0, 328, 24'h000000, 1'b0);
      addVec(0,   0,   1'b0, 1'b0, 324, 24'h000000, 1'b0);
      addVec(170, 90,  1'b1, 1'b0, 324, 24'hE2E2E2, 1'b0);
      addVec(171, 90,  1'b1, 1'b0, 325, 24'hE3E3E3, 1'b0);
      addVec(639, 479, 1'b1, 1'b0, 326, 24'h000000, 1'b0);
      runTable(0, 1, "A");

      // B: scale 2 replication, line replay, frame end
      doReset();
      nVec = 0;
      addVec(0, 0, 1'b0, 1'b0, 0, 24'h000000, 1'b0);
      for (int y = 1; y <= 4; y++) begin
         yb = (y >= 3) ? 4 : 0;
         addVec(1, y, 1'b1, 1'b0, yb, 24'h000000, 1'b0);
         for (int x = 2; x <= 9; x++) begin
            a = yb + (x - 2) / 2;
            addVec(x, y, 1'b1, 1'b0, a, {3{ramData(18'(a), 8'h80)}}, (y == 4 && x == 9));
         end
         addVec(10, y, 1'b1, 1'b0, (y == 2 || y == 3) ? 4 : 0, 24'h000000, 1'b0);
      end
      runTable(1, 1, "B");

      // C: three-cycle RAM, colour appears five edges after the pixel
      doReset();
      nVec = 0;
      addVec(0,   0,  1'b0, 1'b0, 324, 24'h000000, 1'b0);
      addVec(169, 90, 1'b1, 1'b0, 324, BC,         1'b0);
      addVec(170, 90, 1'b1, 1'b0, 324, 24'h5A5A5A, 1'b0);
      addVec(171, 90, 1'b1, 1'b0, 325, 24'h5B5B5B, 1'b0);
      addVec(600, 90, 1'b1, 1'b0, 326, 24'h000000, 1'b0);
      runTable(2, 3, "C");

      // Reset in the middle of a frame: black and parked until next (0,0)
      doReset();
      applyStimulus(0, 0, 1'b0, 1'b0);
      for (int x = 170; x < 176; x++) applyStimulus(x, 90, 1'b1, 1'b0);
      applyStimulus(300, 200, 1'b1, 1'b0);
      rst = 1'b1;
      for (int x = 301; x < 310; x++) applyStimulus(x, 200, 1'b1, 1'b0);
      checkOutput("midrst addr held", 32'(addrA), 32'd324);
      rst = 1'b0;
      for (int x = 310; x < 316; x++) begin
         applyStimulus(x, 200, 1'b1, 1'b0);
         checkOutput($sformatf("midrst addr x=%0d", x), 32'(addrA), 32'd324);
         checkOutput($sformatf("midrst rgb x=%0d", x), 32'({rA, gA, bA}), 32'd0);
      end
      applyStimulus(0, 0, 1'b0, 1'b0);
      checkOutput("resync origin addr", 32'(addrA), 32'd324);
      applyStimulus(170, 90, 1'b1, 1'b0);
      checkOutput("resync first addr", 32'(addrA), 32'd324);
      applyStimulus(171, 90, 1'b1, 1'b0);
      checkOutput("resync second addr", 32'(addrA), 32'd325);
      applyStimulus(500, 90, 1'b1, 1'b0);
      checkOutput("resync first rgb", 32'({rA, gA, bA}), 32'hE2E2E2);
      applyStimulus(501, 90, 1'b1, 1'b0);
      checkOutput("resync second rgb", 32'({rA, gA, bA}), 32'hE3E3E3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/scaled_window_printer.md
Name: scaled_window_printer

Overview:
- Parametrised successor to the VGA framed pixel printer in the de1-soc/vga path.
- Places an IMG_W x IMG_H image from video RAM at (X_START, Y_START), with integer pixel replication by SCALE.
- Computes the RAM address from the raster position, not a free-running counter, so it cannot drift; aligns returned RAM data to the RAM read latency.
- Drives 8-bit RGB in grayscale or RGB332 palette mode and flags end-of-image per frame.

Parameters:
- X_START, 170, window left column (screen pixels)
- Y_START, 90, window top row
- IMG_W, 300, image width in source pixels
- IMG_H, 300, image height in source pixels
- SCALE, 1, replication factor (1..4); window spans IMG_W*SCALE x IMG_H*SCALE
- ADDR_W, 18, RAM address width
- BASE_ADDR, 324, RAM address of source pixel (0,0)
- RD_LATENCY, 1, cycles from address to valid color (1..3)
- BORDER_COLOR, 8'hFF, border gray level (BORDER_EN only)

Ports:
- vga_clk  in  1  pixel clock
- rst  in  1  asynchronous active-high reset
- video_on  in  1  timing generator active-area flag
- pixel_x  in  10  current column
- pixel_y  in  10  current row
- color  in  8  RAM read data, RD_LATENCY cycles after address
- mode  in  1  0 = grayscale replicate, 1 = RGB332 expand
- address  out  ADDR_W  RAM read address
- red, green, blue  out  8 each  pixel output
- frame_done  out  1  one-cycle pulse after last image pixel fetched

Behaviour:
- Reset (async, rst=1): address=BASE_ADDR; red/green/blue=0; frame_done=0; counters cleared; state=WAIT_SYNC; all pipeline valid bits cleared.
- The interface is fixed: one clock, vga_clk; rst is asynchronous and active-high.
- States:
  - WAIT_SYNC: address held at BASE_ADDR, output black. Enter ACTIVE in the cycle pixel_x==0 && pixel_y==0; mode latched into mode_q in that cycle.
  - ACTIVE: normal operation. Re-latch mode_q and clear counters at every (0,0), which resyncs the frame. Mid-frame mode changes take effect next frame.
- in_win = video_on and X_START <= pixel_x < X_START+IMG_W*SCALE and Y_START <= pixel_y < Y_START+IMG_H*SCALE.
- Counters: sx in 0..SCALE-1, col in 0..IMG_W-1, sy in 0..SCALE-1, row in 0..IMG_H-1, and row_base (ADDR_W bits).
  - Counters advance only on in_win cycles in ACTIVE.
  - sx wraps, then col increments.
  - At col wrap (end of window line), sy increments; the same row is replayed until sy wraps. Then row increments and row_base += IMG_W.
  - At the final wrap (row==IMG_H-1, col==IMG_W-1, sx==sy==SCALE-1): all counters and row_base go to 0, frame_done pulses the next cycle.
- address register <= BASE_ADDR + row_base + col, with no multiplier.
  - Updated every cycle in ACTIVE, so address lags pixel_x by 1 cycle.
  - Outside the window it holds the next pixel to be fetched.
- Alignment: a shift register of depth RD_LATENCY carries in_win (plus the border flag).
  - RGB is registered from color and the delayed flag.
  - Total latency from pixel_x/pixel_y to RGB is RD_LATENCY+2 cycles. The timing generator compensates its sync signals by the same amount.
- Colour:
  - mode_q=0: red=green=blue=color.
  - mode_q=1: red={c[7:5],c[7:5],c[7:6]}, green={c[4:2],c[4:2],c[4:3]}, blue={c[1:0] repeated 4x}.
  - A delayed flag of 0, or video_on low at the sampled cycle, gives black.
- Boundaries:
  - Window touching screen edge: no wrap into the next line.
  - video_on low mid-window: counters do not advance.
  - rst mid-frame: WAIT_SYNC until the next (0,0); no partial image is drawn.
  - Address arithmetic is modulo 2^ADDR_W. BASE_ADDR+IMG_W*IMG_H must fit; otherwise elaboration $error.

Optional Feature:
- Macro SCALED_WINDOW_PRINTER_BORDER_EN.
- Defined: pixels in the one-pixel ring just outside the window (video_on and not in_win) output BORDER_COLOR on all three channels. The ring flag goes through the same delay line; counters are unaffected.
- Undefined: the ring is black; no extra logic.

Decomposition:
- Package vga_pkg: screen constants H_ACTIVE=640, V_ACTIVE=480, pixel coordinate type (10-bit), rgb888 struct, BLACK constant, rgb332_expand function.
- One sub-module: latency_shift (parametrised depth/width delay line), reused by the timing generator.

Test Plan:
- Reset then raster sweep, defaults: first in-window pixel (170,90) gives address=324 one cycle later. Last (469,389) gives address=90323, then frame_done pulses once; RGB black outside [170,470)x[90,390).
- SCALE=2, IMG_W=4, IMG_H=2, BASE_ADDR=0: addresses per window line 0,0,1,1,2,2,3,3. Lines 0 and 1 repeat 0..3; lines 2 and 3 give 4..7.
- RD_LATENCY=3, color=8'h5A driven for address 324: RGB=5A/5A/5A exactly 5 cycles after pixel (170,90).
- mode=1, color=8'hE3: red=FF, green=00, blue=FF. Toggling mode mid-frame changes output only after the next (0,0).
- rst asserted at (300,200), released at (310,200): RGB stays black and address=324 until (0,0), then the frame renders correctly.
- BORDER_EN defined: (169,90) and (470,389) give BORDER_COLOR; undefined gives black; in-window pixels unchanged in both builds.
